// File: rtl/input_debounce_sync.sv
// Push-button / slide-switch conditioner: 2-FF sync, per-channel debounce,
// edge pulses, sticky rising-edge events and a maskable interrupt.

module input_debounce_chan #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_i != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_i;
                rise_d  = sync_i;
                fall_d  = ~sync_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

module input_debounce_sync #(
    parameter int NUM_IN          = 12,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_IN-1:0] pin_i,
    output logic [NUM_IN-1:0] level_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic [NUM_IN-1:0] event_o,
    input  logic [NUM_IN-1:0] clr_i,
    input  logic [NUM_IN-1:0] irq_en_i,
    output logic              irq_o
);
    logic [NUM_IN-1:0] s1_q, s2_q;
    logic [NUM_IN-1:0] event_q, event_d;
    logic              irq_q, irq_d;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_chan
        input_debounce_chan #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .sync_i (s2_q[g]),
            .level_o(level_o[g]),
            .rise_o (rise_o[g]),
            .fall_o (fall_o[g])
        );
    end

    // Set has priority over a simultaneous clear.
    assign event_d = rise_o | (event_q & ~clr_i);
    assign irq_d   = |(event_q & irq_en_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q    <= '0;
            s2_q    <= '0;
            event_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            event_q <= event_d;
            irq_q   <= irq_d;
        end
    end

    assign event_o = event_q;
    assign irq_o   = irq_q;
endmodule

// File: doc/input_debounce_sync.md
Name: input_debounce_sync

Overview:
- Per-channel input conditioner for the board push buttons and slide switches.
- Sits between the FPGA pins and the CV32E40P FPGA top / UART debugger logic in the 25 MHz domain.
- Synchronises each asynchronous pin, debounces it with a per-channel stability counter, and produces clean levels, one-cycle edge pulses and sticky, maskable event flags for software/LED use.

Parameters:
- NUM_IN, 12, number of channels (4 push buttons + 8 switches; bit order pb0..pb3, sw0..sw7).
- CNT_W, 20, width of each debounce counter.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz); legal range 1 .. 2^CNT_W-1.

Ports:
- clk_i  input  1  system clock (25 MHz PLL output).
- rst_ni  input  1  synchronous active-low reset.
- pin_i  input  NUM_IN  raw asynchronous button/switch pins.
- level_o  output  NUM_IN  debounced stable level.
- rise_o  output  NUM_IN  one-cycle pulse on accepted 0->1 change.
- fall_o  output  NUM_IN  one-cycle pulse on accepted 1->0 change.
- event_o  output  NUM_IN  sticky rising-edge flags.
- clr_i  input  NUM_IN  per-bit clear of event_o (level, active high).
- irq_en_i  input  NUM_IN  per-bit interrupt enable.
- irq_o  output  1  registered OR of (event_o & irq_en_i).

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset: sampled only on the rising edge of clk_i while rst_ni=0. On reset, the following all become 0:
  - both synchroniser stages, all counters
  - level_o, rise_o, fall_o, event_o, irq_o
- Reset asserted mid-count discards the partial count. An input held high through reset is re-accepted after the normal latency.
- Synchroniser: 2-FF chain per bit (s1, s2). Only s2 is used downstream.
- Debounce, per channel, each edge:
  - s2 == level: counter <= 0.
  - s2 != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != level and counter == DEBOUNCE_CYCLES-1: level <= s2, counter <= 0, and rise or fall pulses for exactly this one cycle.
- Latency: a pin change first captured into s1 at edge k appears on level_o/rise_o/fall_o after edge k+1+DEBOUNCE_CYCLES.
- Glitches: any return of s2 to the current level before acceptance resets the counter. A glitch shorter than DEBOUNCE_CYCLES cycles (after sync) never changes level_o.
- Mutual exclusion: rise_o and fall_o are never both 1 on a channel. Channels are fully independent.
- Sticky event: event[i] <= rise[i] | (event[i] & ~clr_i[i]).
  - Set wins over a simultaneous clear.
  - Clear held for multiple cycles keeps the bit at 0 unless a new rise occurs.
  - fall_o does not set event_o.
- irq_o: registered one cycle after event_o/irq_en_i, equal to |(event_o & irq_en_i). Deasserts one cycle after the last enabled event is cleared or disabled.
- Counter saturation: none needed. The counter never exceeds DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES=1: a change is accepted on the first cycle s2 differs from level.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold rst_ni=0 with pin_i=12'hFFF for 3 cycles -> all outputs 0; release -> level_o=12'hFFF exactly 6 edges after the first sampling edge, rise_o=12'hFFF for one cycle, event_o=12'hFFF.
- Clean press: pin_i[0] 0->1 held -> level_o[0]=1 after 6 edges, rise_o[0] single-cycle pulse, event_o[0]=1; with irq_en_i[0]=1, irq_o=1 one cycle later.
- Glitch rejection: pin_i[5] high for 3 cycles then low -> level_o[5], rise_o[5], event_o[5] remain 0. High for 4 cycles -> accepted.
- Bounce: pin_i[2] toggles 1,0,1,0,1 at one-cycle spacing, then holds 1 -> exactly one rise_o[2] pulse, 4 stable cycles after the final transition reaches s2.
- Clear vs set: clr_i[1]=1 on the same cycle rise_o[1]=1 -> event_o[1] stays 1. clr_i[1]=1 next cycle -> event_o[1]=0 and irq_o drops one cycle later. Release -> fall_o[1] pulses, event_o[1] stays 0.
- Reset mid-count: rst_ni=0 for 1 cycle while counter[3]=2 with pin high -> counter restarts; level_o[3]=1 occurs 6 edges after reset release, not earlier.
